// File: rtl/input_port_buffer.sv
// input_port_buffer: router input-port FIFO with packet-protocol checking.
//   Flits are pushed with an in_valid/in_ready handshake. A two-state
//   protocol FSM (IDLE expects a header, PKT expects a body or a tail) drops
//   malformed flits and flags each drop with a one-cycle proto_err pulse.
//   The head flit is offered to the arbiter through req/grant. length gives
//   the packet length for the arbiter timer.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_flit     upstream flit; in_ready = room available
//   grant / req          arbiter handshake; pop = grant && req
//   flit_id, out_flit    head flit (0 when empty)
//   length               header length of the current packet
//   count                occupancy, 0..DEPTH
//   proto_err            pulse one cycle after a malformed flit is dropped
// DEPTH must be a power of 2 and at least 2. FLIT_W must be at least 16.
module input_port_buffer #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [FLIT_W-1:0]        in_flit,
  output logic                     in_ready,
  input  logic                     grant,
  output logic                     req,
  output logic [2:0]               flit_id,
  output logic [11:0]              length,
  output logic [FLIT_W-1:0]        out_flit,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] ID_HDR  = 3'b001;
  localparam logic [2:0] ID_BODY = 3'b010;
  localparam logic [2:0] ID_TAIL = 3'b100;

  typedef enum logic {IDLE, PKT} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [11:0]       hdr_len_q, hdr_len_d;
  logic              proto_err_q, proto_err_d;
  logic [FLIT_W-1:0] mem_q [DEPTH];

  logic              push, pop, wr, well_formed, not_empty;
  logic [2:0]        in_id, head_id;
  logic [FLIT_W-1:0] head;

  // Ready and req both come from registered count only. A pop therefore
  // cannot open a slot in the same cycle, and a full buffer refuses a push
  // even while it is being drained.
  assign not_empty = (count_q != '0);
  assign in_ready  = rst ? 1'b1 : (count_q < CW'(DEPTH));
  assign req       = !rst && not_empty;

  assign push  = in_valid && in_ready;
  assign pop   = grant && req;
  assign in_id = in_flit[FLIT_W-1 -: 3];

  assign head     = mem_q[rd_ptr_q];
  assign head_id  = head[FLIT_W-1 -: 3];
  assign out_flit = req ? head : '0;
  assign flit_id  = out_flit[FLIT_W-1 -: 3];
  // A header at the head supplies its own length. Bodies and tails use the
  // length latched when their header was popped.
  assign length   = rst ? 12'd0 :
                    (req && head_id == ID_HDR) ? head[11:0] : hdr_len_q;
  assign proto_err = proto_err_q;
  assign count     = count_q;

  // Protocol FSM: classify the incoming flit and advance on well-formed pushes.
  always_comb begin
    state_d     = state_q;
    well_formed = 1'b0;
    case (state_q)
      IDLE: begin
        well_formed = (in_id == ID_HDR);
        if (push && well_formed) state_d = PKT;
      end
      PKT: begin
        well_formed = (in_id == ID_BODY) || (in_id == ID_TAIL);
        if (push && in_id == ID_TAIL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A malformed flit still completes its handshake. It is dropped here.
  assign wr = push && well_formed;

  always_comb begin
    wr_ptr_d    = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    hdr_len_d   = (pop && head_id == ID_HDR) ? head[11:0] : hdr_len_q;
    proto_err_d = push && !well_formed;
    count_d     = count_q;
    case ({wr, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hdr_len_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hdr_len_q   <= hdr_len_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage is not reset. Stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (wr && !rst) mem_q[wr_ptr_q] <= in_flit;
  end
endmodule

// File: tb/tb_input_port_buffer.sv
module tb_input_port_buffer;
  logic        clk = 1'b0;
  logic        rst, in_valid, grant;
  logic [31:0] in_flit;
  logic        in_ready, req, proto_err;
  logic [2:0]  flit_id;
  logic [11:0] length;
  logic [31:0] out_flit;
  logic [2:0]  count;

  input_port_buffer #(.DEPTH(4), .FLIT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit),
    .in_ready(in_ready), .grant(grant), .req(req), .flit_id(flit_id),
    .length(length), .out_flit(out_flit), .count(count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Scoreboard plus a reference model of occupancy, FSM and latched length.
  logic [31:0] sb[$];
  int          n_cmp = 0, n_err = 0;
  int          mcount = 0;
  bit          mpkt = 0;
  logic [11:0] mhdr_len = '0;
  bit          exp_err = 0;
  bit          acc = 0;

  function automatic logic [31:0] hdr(input logic [11:0] len);
    return {3'b001, 17'h0a5a5, len};
  endfunction
  function automatic logic [31:0] body(input int x);
    return {3'b010, 29'(x)};
  endfunction
  function automatic logic [31:0] tail(input int x);
    return {3'b100, 29'(x)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-low-phase, update the model, check the
  // registered results after the edge, and return at the next negedge.
  task automatic tick();
    logic        er, eq, mp, mpop, wf;
    logic [2:0]  id;
    logic [31:0] hd;
    #1;
    acc = 0;
    if (rst) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_req", req, 0);
      chk("rst_out_flit", out_flit, 0);
      chk("rst_flit_id", flit_id, 0);
      chk("rst_length", length, 0);
    end else begin
      er = (mcount < 4);
      eq = (mcount != 0);
      chk("in_ready", in_ready, er);
      chk("req", req, eq);
      if (eq) begin
        hd = sb[0];
        chk("out_flit", out_flit, hd);
        chk("flit_id", flit_id, hd[31:29]);
        chk("length", length, (hd[31:29] == 3'b001) ? hd[11:0] : mhdr_len);
      end else begin
        hd = '0;
        chk("out_flit_empty", out_flit, 0);
        chk("length_empty", length, mhdr_len);
      end
      mp   = in_valid && er;
      mpop = grant && eq;
      id   = in_flit[31:29];
      wf   = mpkt ? (id == 3'b010 || id == 3'b100) : (id == 3'b001);
      acc  = mp;
      if (mpop) begin
        void'(sb.pop_front());
        if (hd[31:29] == 3'b001) mhdr_len = hd[11:0];
      end
      if (mp && wf) begin
        sb.push_back(in_flit);
        if (id == 3'b001) mpkt = 1;
        else if (id == 3'b100) mpkt = 0;
      end
      mcount  = mcount + ((mp && wf) ? 1 : 0) - (mpop ? 1 : 0);
      exp_err = mp && !wf;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      mcount = 0; mpkt = 0; mhdr_len = '0; exp_err = 0;
    end
    chk("proto_err", proto_err, exp_err);
    chk("count", count, mcount);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] f, input logic g);
    in_valid = 1; in_flit = f; grant = g;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc) break;
    end
    n_cmp++;
    assert (acc) else begin
      n_err++;
      $error("FAIL push_timeout observed=not_accepted expected=accepted flit=%0h", f);
    end
    in_valid = 0;
  endtask

  task automatic idle(input int n, input logic g);
    in_valid = 0; grant = g;
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1; in_valid = 0; grant = 0;
    repeat (n) tick();
    rst = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; grant = 0; in_flit = '0;
    @(negedge clk);
    do_reset(2);

    // Single packet, grant held: header / body / tail on consecutive cycles.
    push(hdr(12'd20), 1);
    push(body(1), 1);
    push(tail(2), 1);
    idle(3, 1);
    chk("pkt_drained", count, 0);

    // Fill with grant low. The 5th flit stalls upstream until a pop frees a slot.
    push(hdr(12'd7), 0);
    push(body(11), 0);
    push(body(12), 0);
    push(body(13), 0);
    chk("full_count", count, 4);
    in_valid = 1; in_flit = body(14); grant = 0;
    tick(); tick();
    push(body(14), 1);
    push(tail(15), 1);
    idle(8, 1);

    // Simultaneous push and pop at count 2, long enough to wrap pointers.
    push(hdr(12'd300), 0);
    push(body(20), 0);
    for (int i = 0; i < 10; i++) push(body(21 + i), 1);
    chk("steady_count", count, 2);
    push(tail(40), 1);
    idle(6, 1);

    // Protocol errors: body in IDLE, header, header in PKT, tail.
    push(body(50), 0);
    push(hdr(12'd9), 0);
    push(hdr(12'd10), 0);
    push(tail(51), 0);
    chk("err_stored", count, 2);
    push({3'b111, 29'd5}, 0);
    idle(4, 1);

    // Reset while three flits of an open packet are buffered.
    push(hdr(12'd33), 0);
    push(body(60), 0);
    push(body(61), 0);
    do_reset(1);
    push(body(62), 0);
    idle(1, 0);

    // Grant while empty must change nothing; later traffic still in order.
    idle(5, 1);
    push(hdr(12'd4), 1);
    push(tail(70), 1);
    idle(3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
